// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// The optional overflow flag is enabled by defining SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_add.sv
// Single-bit full-add cell; the additive mirror of the subtractor bit cells.
module full_add
    import serial_adder_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ cin;
    assign co = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-add cell and a carry flop, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t        state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] sum_next;

    full_add u_cell (
        .x   (a_sr[0]),
        .y   (b_sr[0]),
        .cin (carry),
        .s   (s_bit),
        .co  (c_next)
    );

    // Partial sum with the current bit entering at the MSB; complete on the last bit.
    assign sum_next = {s_bit, sum_sr};

    // NOTE: every register below uses <= so all state advances from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_next[WIDTH-1:1];
                    carry  <= c_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // Results land in one edge, so sum/cout never show a partial value.
                        sum   <= sum_next;
                        cout  <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry ^ c_next;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: timeline model of a+b plus directed literal checks.
// Build with SERIAL_ADDER_OVF_EN defined to also check the overflow flag.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request completes exactly WIDTH edges later with a+b.
    logic             m_valid = 1'b0;
    logic             m_active = 1'b0;
    int               m_edge = 0;
    int               m_acc = 0;
    logic [WIDTH-1:0] m_a = '0;
    logic [WIDTH-1:0] m_b = '0;
    logic [WIDTH:0]   m_full;
    logic             e_busy = 1'b0;
    logic             e_done = 1'b0;
    logic [WIDTH-1:0] e_sum = '0;
    logic             e_cout = 1'b0;
    logic             e_ovf = 1'b0;

    assign m_full = {1'b0, m_a} + {1'b0, m_b};

    always @(posedge clk) begin
        m_valid <= 1'b1;
        m_edge  <= m_edge + 1;
        if (rst) begin
            m_active <= 1'b0;
            e_busy   <= 1'b0;
            e_done   <= 1'b0;
            e_sum    <= '0;
            e_cout   <= 1'b0;
            e_ovf    <= 1'b0;
        end else begin
            e_done <= 1'b0;
            if (m_active && m_edge == m_acc + WIDTH) begin
                m_active <= 1'b0;
                e_busy   <= 1'b0;
                e_done   <= 1'b1;
                e_sum    <= m_full[WIDTH-1:0];
                e_cout   <= m_full[WIDTH];
                e_ovf    <= (m_a[WIDTH-1] == m_b[WIDTH-1]) && (m_full[WIDTH-1] != m_a[WIDTH-1]);
            end else if (!m_active && start) begin
                m_active <= 1'b1;
                m_acc    <= m_edge;
                m_a      <= a;
                m_b      <= b;
                e_busy   <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_busy", 32'(busy), 32'(e_busy));
            check("cyc_done", 32'(done), 32'(e_done));
            check("cyc_sum",  32'(sum),  32'(e_sum));
            check("cyc_cout", 32'(cout), 32'(e_cout));
`ifdef SERIAL_ADDER_OVF_EN
            check("cyc_ovf",  32'(ovf),  32'(e_ovf));
`endif
        end
    end

    // Pulse start for one accepting edge; returns at the negedge after that edge.
    task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done is seen; busy cycles include the current one.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) return;
            if (busy === 1'b1) busy_cnt++;
        end
        check("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic check_ovf(input string name, input logic exp);
`ifdef SERIAL_ADDER_OVF_EN
        check(name, 32'(ovf), 32'(exp));
`else
        if (exp === 1'bx) $display("unused %s", name);
`endif
    endtask

    int lat;
    int bcnt;
    logic [WIDTH-1:0] held;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_sum",  32'(sum),  32'(0));
        check("rst_cout", 32'(cout), 32'(0));

        // 1: zero operands, done WIDTH edges after the accepting edge
        launch(8'h00, 8'h00);
        wait_done(lat, bcnt);
        check("t1_latency", 32'(lat), 32'(WIDTH));
        check("t1_sum", 32'(sum), 32'h00);
        check("t1_cout", 32'(cout), 32'(0));
        check_ovf("t1_ovf", 1'b0);

        // 2: wrap-around, busy for WIDTH cycles then one done cycle with busy low
        launch(8'hFF, 8'h01);
        wait_done(lat, bcnt);
        check("t2_busy_cycles", 32'(bcnt), 32'(WIDTH));
        check("t2_busy_in_done", 32'(busy), 32'(0));
        check("t2_sum", 32'(sum), 32'h00);
        check("t2_cout", 32'(cout), 32'(1));
        check_ovf("t2_ovf", 1'b0);
        @(negedge clk);
        check("t2_done_one_cycle", 32'(done), 32'(0));

        // 3: signed overflow without carry, then both
        launch(8'h5A, 8'h3C);
        wait_done(lat, bcnt);
        check("t3a_sum", 32'(sum), 32'h96);
        check("t3a_cout", 32'(cout), 32'(0));
        check_ovf("t3a_ovf", 1'b1);
        launch(8'h80, 8'h80);
        wait_done(lat, bcnt);
        check("t3b_sum", 32'(sum), 32'h00);
        check("t3b_cout", 32'(cout), 32'(1));
        check_ovf("t3b_ovf", 1'b1);

        // 4: start during RUN is ignored and sum holds the prior result
        held = sum;
        launch(8'h12, 8'h34);
        repeat (3) @(negedge clk);
        check("t4_sum_held", 32'(sum), 32'(held));
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        check("t4_still_busy", 32'(busy), 32'(1));
        wait_done(lat, bcnt);
        check("t4_sum", 32'(sum), 32'h46);
        check("t4_cout", 32'(cout), 32'(0));

        // 5: start held high, back-to-back results WIDTH+1 cycles apart
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        @(negedge clk);
        wait_done(lat, bcnt);
        check("t5a_sum", 32'(sum), 32'h03);
        a = 8'h10;
        b = 8'h20;
        wait_done(lat, bcnt);
        check("t5_spacing", 32'(lat), 32'(WIDTH + 1));
        check("t5b_sum", 32'(sum), 32'h30);
        start = 1'b0;
        @(negedge clk);

        // 6: reset mid-RUN aborts and clears, then a fresh request completes
        launch(8'hAA, 8'h55);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'(0));
        check("t6_sum", 32'(sum), 32'(0));
        check("t6_cout", 32'(cout), 32'(0));
        check("t6_done", 32'(done), 32'(0));
        repeat (WIDTH + 2) @(negedge clk);
        launch(8'hAA, 8'h55);
        wait_done(lat, bcnt);
        check("t6_sum_after", 32'(sum), 32'hFF);
        check("t6_cout_after", 32'(cout), 32'(0));
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
